// File: rtl/fmult_accum.sv
// Float x coefficient multiply-accumulate for the pole/zero predictor.
// Eight products are summed serially into SEZ (zeros only) and SE (zeros + poles).
module fmult_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] SR0,
  input  logic [10:0] DQ0,
  input  logic        upd,
  input  logic        start,
  input  logic [15:0] B1,
  input  logic [15:0] B2,
  input  logic [15:0] B3,
  input  logic [15:0] B4,
  input  logic [15:0] B5,
  input  logic [15:0] B6,
  input  logic [15:0] A1,
  input  logic [15:0] A2,
  output logic        busy,
  output logic        done,
  output logic [14:0] SEZ,
  output logic [14:0] SE
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nxt;
  logic [5:0][10:0] dq;      // dq[0] is DQ1
  logic [1:0][10:0] sr;      // sr[0] is SR1
  logic [7:0][15:0] coef_q;
  logic [7:0][10:0] fl_q;
  logic [15:0]      acc, prod_q, sezi, sum, w;
  logic [3:0]       idx;

  // One product is registered per cycle and added the following cycle,
  // so index 8 is the drain step that folds in the last product.
  fmult u_fmult (.an(coef_q[idx[2:0]]), .fl(fl_q[idx[2:0]]), .w(w));

  assign sum  = acc + prod_q;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (idx == 4'd8) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dq     <= {6{11'h020}};
      sr     <= {2{11'h020}};
      coef_q <= '0;
      fl_q   <= '0;
      acc    <= '0;
      prod_q <= '0;
      sezi   <= '0;
      idx    <= '0;
      SEZ    <= '0;
      SE     <= '0;
    end else begin
      if (upd) begin
        dq <= {dq[4:0], DQ0};
        sr <= {sr[0], SR0};
      end
      if (state == IDLE && start) begin
        coef_q <= {A2, A1, B6, B5, B4, B3, B2, B1};
        fl_q   <= {sr[1], sr[0], dq[5], dq[4], dq[3], dq[2], dq[1], dq[0]};
        acc    <= '0;
        prod_q <= '0;
        idx    <= '0;
      end else if (state == MAC) begin
        if (idx != 4'd8) prod_q <= w;
        if (idx != 4'd0) acc <= sum;
        if (idx == 4'd6) sezi <= sum;
        if (idx == 4'd8) begin
          SEZ <= sezi[15:1];
          SE  <= sum[15:1];
        end
        idx <= idx + 4'd1;
      end
    end
  end
endmodule

// Combinational coefficient-to-float conversion and float product.
module fmult (
  input  logic [15:0] an,
  input  logic [10:0] fl,
  output logic [15:0] w
);
  logic        an_s, ws;
  logic [13:0] an_sh;
  logic [14:0] neg_t;
  logic [12:0] an_mag;
  logic [3:0]  an_exp;
  logic [18:0] mant_sh;
  logic [5:0]  an_mant;
  logic [4:0]  wexp;
  logic [11:0] prod;
  logic [12:0] rnd;
  logic [7:0]  wmant;
  logic [14:0] wm7, wmag;

  always_comb begin
    an_s  = an[15];
    an_sh = an[15:2];
    neg_t = 15'd16384 - {1'b0, an_sh};
    an_mag = an_s ? neg_t[12:0] : an_sh[12:0];
    an_exp = '0;
    for (int i = 0; i < 13; i++)
      if (an_mag[i]) an_exp = 4'(i + 1);
    mant_sh = {an_mag, 6'b0} >> an_exp;
    an_mant = (an_mag == '0) ? 6'd32 : mant_sh[5:0];
    ws    = fl[10] ^ an_s;
    wexp  = {1'b0, fl[9:6]} + {1'b0, an_exp};
    prod  = {6'b0, fl[5:0]} * {6'b0, an_mant};
    rnd   = {1'b0, prod} + 13'd48;
    wmant = rnd[11:4];
    wm7   = {wmant, 7'b0};
    if (wexp <= 5'd26) wmag = wm7 >> (5'd26 - wexp);
    else               wmag = wm7 << (wexp - 5'd26);
    w = ws ? (16'd0 - {1'b0, wmag}) : {1'b0, wmag};
  end
endmodule

// File: tb/tb_fmult_accum.sv
// Randomized and directed checks of fmult_accum against an arithmetic model.
module tb_fmult_accum;
  logic        clk = 0, reset = 0, upd = 0, start = 0;
  logic [10:0] sr0 = 0, dq0 = 0;
  logic [15:0] cf [8];
  logic        busy, done;
  logic [14:0] sez, se;

  int n_vec = 0, n_err = 0;
  int m_dq [6];
  int m_sr [2];
  int s_f [8];
  int s_c [8];
  int last_sez, last_se;

  always #5 clk = ~clk;

  fmult_accum dut (
    .clk(clk), .reset(reset), .SR0(sr0), .DQ0(dq0), .upd(upd), .start(start),
    .B1(cf[0]), .B2(cf[1]), .B3(cf[2]), .B4(cf[3]), .B5(cf[4]), .B6(cf[5]),
    .A1(cf[6]), .A2(cf[7]), .busy(busy), .done(done), .SEZ(sez), .SE(se)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_w(input int an, input int f);
    int s, sh, mag, ex, mant, fs, fe, fm, ws, we, wm, wmag;
    s   = (an >> 15) & 1;
    sh  = (an & 65535) >> 2;
    mag = s ? (16384 - sh) & 8191 : sh;
    ex  = 0;
    for (int i = 0; i < 13; i++) if ((mag >> i) & 1) ex = i + 1;
    mant = (mag == 0) ? 32 : (mag << 6) >> ex;
    fs = (f >> 10) & 1; fe = (f >> 6) & 15; fm = f & 63;
    ws = fs ^ s;
    we = fe + ex;
    wm = (fm * mant + 48) >> 4;
    wmag = (we <= 26) ? (wm << 7) >> (26 - we) : ((wm << 7) << (we - 26)) & 32767;
    return ws ? (65536 - wmag) & 65535 : wmag;
  endfunction

  task automatic ref_calc(output int e_sez, output int e_se);
    int sum = 0;
    e_sez = 0;
    for (int i = 0; i < 8; i++) begin
      sum = (sum + ref_w(s_c[i], s_f[i])) & 65535;
      if (i == 5) e_sez = sum >> 1;
    end
    e_se = sum >> 1;
  endtask

  // Applies one clock edge; the model delay lines follow the same inputs.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 6; i++) m_dq[i] = 'h020;
      m_sr[0] = 'h020; m_sr[1] = 'h020;
    end else if (upd) begin
      for (int i = 5; i > 0; i--) m_dq[i] = m_dq[i-1];
      m_dq[0] = int'(dq0);
      m_sr[1] = m_sr[0];
      m_sr[0] = int'(sr0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic do_start(input bit up, input logic [10:0] dqv, input logic [10:0] srv,
                          input bit noise);
    int lat, e_sez, e_se;
    bit busy_ok;
    for (int i = 0; i < 6; i++) s_f[i] = m_dq[i];
    s_f[6] = m_sr[0]; s_f[7] = m_sr[1];
    for (int i = 0; i < 8; i++) s_c[i] = int'(cf[i]);
    start = 1; upd = up; dq0 = dqv; sr0 = srv;
    tick();
    start = 0; upd = 0;
    chk("busy_start", busy, 1);
    lat = -1; busy_ok = 1;
    for (int c = 1; c <= 20; c++) begin
      if (noise) begin
        upd = 1'($urandom); start = 1'($urandom);
        dq0 = 11'($urandom); sr0 = 11'($urandom);
        for (int k = 0; k < 8; k++) cf[k] = 16'($urandom);
      end
      tick();
      if (!busy) busy_ok = 0;
      if (done) begin lat = c; break; end
    end
    start = 0; upd = 0;
    chk("busy_run", busy_ok, 1);
    chk("latency", lat, 9);
    ref_calc(e_sez, e_se);
    chk("sez", sez, e_sez);
    chk("se", se, e_se);
    last_sez = sez; last_se = se;
    tick();
    chk("idle_after", {busy, done}, 0);
    chk("sez_hold", sez, e_sez);
  endtask

  task automatic clr_cf();
    for (int i = 0; i < 8; i++) cf[i] = '0;
  endtask

  initial begin
    int dn;
    clr_cf();
    reset = 1; tick(); tick(); reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sez", sez, 0);
    chk("rst_se", se, 0);

    // all-zero coefficients
    do_start(0, '0, '0, 0);
    chk("zero_sez", last_sez, 0);
    chk("zero_se", last_se, 0);

    // positive B1 times DQ1
    do_reset(); dq0 = 11'h1E0; upd = 1; tick(); upd = 0;
    clr_cf(); cf[0] = 16'h4000;
    do_start(0, '0, '0, 0);
    chk("b1pos_sez", last_sez, 67);
    chk("b1pos_se", last_se, 67);

    // negative B1
    do_reset(); dq0 = 11'h1E0; upd = 1; tick(); upd = 0;
    clr_cf(); cf[0] = 16'hC000;
    do_start(0, '0, '0, 0);
    chk("b1neg_sez", last_sez, 'h7FBD);
    chk("b1neg_se", last_se, 'h7FBD);

    // pole term only reaches SE
    do_reset(); sr0 = 11'h1E0; upd = 1; tick(); upd = 0;
    clr_cf(); cf[6] = 16'h4000;
    do_start(0, '0, '0, 0);
    chk("a1_sez", last_sez, 0);
    chk("a1_se", last_se, 67);

    // start and upd on the same edge use pre-shift DQ1
    do_reset(); clr_cf(); cf[0] = 16'h4000;
    do_start(1, 11'h1E0, '0, 0);
    chk("same_edge_sez", last_sez, 0);
    do_start(0, '0, '0, 0);
    chk("second_sez", last_sez, 67);
    do_start(0, '0, '0, 1);

    // reset in the 4th MAC cycle aborts
    do_reset(); clr_cf(); cf[0] = 16'h4000;
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_sez", sez, 0);
    chk("abort_se", se, 0);
    dn = 0;
    for (int c = 0; c < 12; c++) begin tick(); if (done || busy) dn++; end
    chk("abort_no_done", dn, 0);
    cf[0] = 16'h4000;
    do_start(0, '0, '0, 0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        upd = 1'($urandom); dq0 = 11'($urandom); sr0 = 11'($urandom);
        tick();
      end
      upd = 0;
      for (int k = 0; k < 8; k++) cf[k] = 16'($urandom);
      do_start(1'($urandom), 11'($urandom), 11'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
